// File: rtl/fft_frame_loader.sv
// Ping-pong frame buffer that collects a stream of complex samples into full FFT frames.
// Optional build macro FFT_LOADER_PRESCALE_EN: store components arithmetically shifted right by POINT_FFT_POW2.
module fft_frame_loader #(
    parameter int POINT_FFT_POW2 = 4,
    parameter int FRAC_BITS      = 15,
    parameter int POINT_FFT      = 1 << POINT_FFT_POW2
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic signed [1:0][FRAC_BITS:0] s_data_i,
    input  logic                          s_last_i,
    output logic                          frame_valid_o,
    input  logic                          frame_ready_i,
    output logic signed [1:0][FRAC_BITS:0] frame_o [POINT_FFT],
    output logic                          err_o
);
    localparam logic [POINT_FFT_POW2-1:0] LAST_IDX = POINT_FFT_POW2'(POINT_FFT - 1);

    logic signed [1:0][FRAC_BITS:0] mem [2][POINT_FFT];
    logic signed [1:0][FRAC_BITS:0] wdata;

    logic [1:0]                full_q;
    logic                      wptr_q, rptr_q, run_q, err_q;
    logic [POINT_FFT_POW2-1:0] widx_q;

    logic       accept, consume, at_end, complete, store;
    logic [1:0] set_full, clr_full;

    // run_q keeps s_ready_o low through reset and rises on the first edge after release
    assign s_ready_o     = run_q & ~full_q[wptr_q];
    assign frame_valid_o = full_q[rptr_q];
    assign err_o         = err_q;

    assign accept   = s_valid_i & s_ready_o;
    assign consume  = frame_valid_o & frame_ready_i;
    assign at_end   = (widx_q == LAST_IDX);
    assign complete = accept & at_end;
    assign store    = accept & (at_end | ~s_last_i);

    // Completion targets the write bank, consumption the read bank; they never collide
    assign set_full = {complete & wptr_q, complete & ~wptr_q};
    assign clr_full = {consume & rptr_q, consume & ~rptr_q};

`ifdef FFT_LOADER_PRESCALE_EN
    for (genvar c = 0; c < 2; c++) begin : g_scale
        assign wdata[c] = $signed(s_data_i[c]) >>> POINT_FFT_POW2;
    end
`else
    assign wdata = s_data_i;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= '0;
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            widx_q <= '0;
            run_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            run_q  <= 1'b1;
            full_q <= (full_q | set_full) & ~clr_full;
            if (complete) wptr_q <= ~wptr_q;
            if (consume)  rptr_q <= ~rptr_q;
            // an early last discards the partial frame by rewinding the index
            if (accept)   widx_q <= (at_end | s_last_i) ? '0 : widx_q + POINT_FFT_POW2'(1);
            err_q <= accept & (at_end ? ~s_last_i : s_last_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (store) mem[wptr_q][widx_q] <= wdata;
    end

    for (genvar i = 0; i < POINT_FFT; i++) begin : g_out
        assign frame_o[i] = mem[rptr_q][i];
    end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Bench for fft_frame_loader: directed scenarios plus random traffic against a queue-based frame model.
module tb_fft_frame_loader;
    localparam int POW2 = 4;
    localparam int FB   = 15;
    localparam int N    = 1 << POW2;
    localparam int W    = FB + 1;

    typedef logic [2*W-1:0] smp_t;
    typedef smp_t fr_t [N];

    logic                   clk_i = 1'b0;
    logic                   rst_ni = 1'b0;
    logic                   s_valid_i = 1'b0;
    logic                   s_ready_o;
    logic signed [1:0][W-1:0] s_data_i = '0;
    logic                   s_last_i = 1'b0;
    logic                   frame_valid_o;
    logic                   frame_ready_i = 1'b0;
    logic signed [1:0][W-1:0] frame_o [N];
    logic                   err_o;

    fft_frame_loader #(.POINT_FFT_POW2(POW2), .FRAC_BITS(FB)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
        .frame_valid_o(frame_valid_o), .frame_ready_i(frame_ready_i), .frame_o(frame_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_vec = 0;
    int n_err = 0;

    // reference model: completed frames waiting for the consumer, plus the frame being filled
    fr_t  frames[$];
    smp_t part[$];
    bit   m_run = 0;
    bit   m_err = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int scale(int v);
`ifdef FFT_LOADER_PRESCALE_EN
        int q = v / N;
        if ((v % N) != 0 && v < 0) q--;
        return q;
`else
        return v;
`endif
    endfunction

    function automatic bit m_ready();
        return m_run && frames.size() < 2;
    endfunction

    task automatic check_outputs();
        chk("s_ready", {31'd0, s_ready_o}, {31'd0, m_ready()});
        chk("frame_valid", {31'd0, frame_valid_o}, {31'd0, frames.size() > 0});
        chk("err", {31'd0, err_o}, {31'd0, m_err});
        if (frames.size() > 0)
            for (int i = 0; i < N; i++)
                chk($sformatf("frame[%0d]", i), {frame_o[i]}, frames[0][i]);
    endtask

    task automatic model_edge(bit acc, bit cons, bit l, int re, int im);
        m_run = 1;
        m_err = 0;
        if (cons) frames.delete(0);
        if (acc) begin
            if (l && part.size() < N - 1) begin
                m_err = 1;
                part.delete();
            end else begin
                part.push_back({W'(scale(im)), W'(scale(re))});
                if (part.size() == N) begin
                    fr_t f;
                    foreach (f[i]) f[i] = part[i];
                    frames.push_back(f);
                    m_err = !l;
                    part.delete();
                end
            end
        end
    endtask

    // called at posedge+1: drive, compare, then advance one clock
    task automatic step(bit v, bit l, int re, int im, bit fr);
        bit acc, cons;
        s_valid_i = v; s_last_i = l; frame_ready_i = fr;
        s_data_i[0] = W'(re); s_data_i[1] = W'(im);
        check_outputs();
        acc  = v && m_ready();
        cons = frames.size() > 0 && fr;
        @(posedge clk_i); #1;
        model_edge(acc, cons, l, re, im);
    endtask

    task automatic idle(int n, bit fr);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, fr);
    endtask

    task automatic do_reset();
        s_valid_i = 0;
        #2 rst_ni = 0;
        #1;
        frames.delete(); part.delete(); m_run = 0; m_err = 0;
        chk("rst_s_ready", {31'd0, s_ready_o}, 32'd0);
        chk("rst_frame_valid", {31'd0, frame_valid_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #2 rst_ni = 1;
        @(posedge clk_i); #1;
        m_run = 1;
    endtask

    initial begin
        #3;
        chk("init_s_ready", {31'd0, s_ready_o}, 32'd0);
        chk("init_frame_valid", {31'd0, frame_valid_o}, 32'd0);
        chk("init_err", {31'd0, err_o}, 32'd0);
        #9 rst_ni = 1;
        @(posedge clk_i); #1;
        m_run = 1;

        // clean frame with consumer always ready
        for (int k = 0; k < N; k++) step(1, k == N - 1, k * 1000, -k, 1);
        idle(3, 1);

        // consumer stalled: both banks fill, then release one frame
        for (int k = 0; k < 40; k++) step(1, (k % N) == N - 1, k * 731 - 9000, 50 - k, 0);
        idle(3, 0);
        step(0, 0, 0, 0, 1);
        idle(3, 0);
        idle(3, 1);

        // early last discards the partial frame
        for (int k = 0; k < 22; k++) step(1, k == 5 || k == 21, k * 100, k, 1);
        idle(2, 1);

        // missing last still publishes
        for (int k = 0; k < N; k++) step(1, 0, -k * 2000, k * 3, 1);
        idle(2, 1);

        // frame 1 completes on the edge frame 0 is consumed
        for (int k = 0; k < 2 * N; k++) step(1, (k % N) == N - 1, k * 17 - 300, -k * 5, k == 2 * N - 1);
        idle(3, 1);

        // reset mid-frame
        for (int k = 0; k < 7; k++) step(1, 0, k + 1, k + 2, 0);
        do_reset();
        idle(3, 0);
        for (int k = 0; k < N; k++) step(1, k == N - 1, k * 999, -k * 999, 0);
        idle(2, 0);
        idle(2, 1);

        // random traffic
        for (int t = 0; t < 3000; t++) begin
            bit v, l, fr;
            int re, im;
            v  = $urandom_range(3) != 0;
            fr = $urandom_range(1);
            l  = (part.size() == N - 1) ? ($urandom_range(9) != 0) : ($urandom_range(19) == 0);
            re = int'($urandom_range(65535)) - 32768;
            im = int'($urandom_range(65535)) - 32768;
            step(v, l, re, im, fr);
            if ($urandom_range(499) == 0) do_reset();
        end
        idle(4, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fft_frame_loader.md
FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

Interface
REQ-001 SHALL have parameter POINT_FFT_POW2, default 4: log2 of the frame length.
REQ-002 SHALL have parameter FRAC_BITS, default 15: the fractional bits of each signed component; each component is FRAC_BITS+1 bits wide.
REQ-003 SHALL have parameter POINT_FFT, default 1<<POINT_FFT_POW2: the number of samples per frame.
REQ-004 SHALL have port clk_i  in  1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni  in  1: asynchronous, active-low reset.
REQ-006 SHALL have port s_valid_i  in  1: an input sample is present.
REQ-007 SHALL have port s_ready_o  out  1: the loader can accept a sample.
REQ-008 SHALL have port s_data_i  in  signed [1:0][FRAC_BITS:0]: the sample; [0] is Re, [1] is Im.
REQ-009 SHALL have port s_last_i  in  1: marks the final sample of a frame.
REQ-010 SHALL have port frame_valid_o  out  1: a complete frame is presented.
REQ-011 SHALL have port frame_ready_i  in  1: the downstream FFT consumer accepts the frame.
REQ-012 SHALL have port frame_o  out  signed [1:0][FRAC_BITS:0] [POINT_FFT]: the frame in natural order, index 0 being the first sample received; it feeds the FFT data_i directly.
REQ-013 SHALL have port err_o  out  1: a one-cycle pulse on a framing error.

Function
REQ-014 A sample SHALL be accepted on a clock edge where s_valid_i and s_ready_o are both 1.
REQ-015 The block SHALL contain two frame banks, A and B, in a ping-pong arrangement.
REQ-016 Each bank SHALL be in state FREE or FULL.
REQ-017 The block SHALL keep a write-bank pointer, a read-bank pointer and a write index widx (POINT_FFT_POW2 bits).
REQ-018 s_ready_o SHALL be 1 exactly when the write bank is FREE; it SHALL be combinational from registered state only.
REQ-019 An accepted sample SHALL be stored in write-bank[widx], and widx SHALL increment.
REQ-020 When the accepted sample has widx==POINT_FFT-1, the write bank SHALL become FULL, widx SHALL wrap to 0, and the write pointer SHALL toggle.
REQ-021 frame_valid_o SHALL be 1 exactly when the read bank is FULL.
REQ-022 frame_o SHALL be driven from the read bank and SHALL be held stable while frame_valid_o=1 and frame_ready_i=0.
REQ-023 Latency: frame_valid_o SHALL rise on the edge after the edge that accepts the last sample, provided the read bank was FREE or was consumed.
REQ-024 When frame_valid_o and frame_ready_i are both 1 at an edge, the read bank SHALL become FREE and the read pointer SHALL toggle.
REQ-025 If a frame completes and a frame is consumed on the same edge, both transitions SHALL take effect, and neither SHALL be lost.
REQ-026 With frame_ready_i held at 1, s_ready_o SHALL stay at 1 continuously, giving one sample per cycle with no bubbles.
REQ-027 When both banks are FULL, s_ready_o SHALL be 0 and no sample SHALL be stored.
REQ-028 If s_last_i=1 on an accepted sample with widx<POINT_FFT-1, err_o SHALL pulse, the partial frame SHALL be discarded, widx SHALL return to 0, and the bank SHALL stay FREE.
REQ-029 If s_last_i=0 on an accepted sample with widx==POINT_FFT-1, the frame SHALL still complete and be published, and err_o SHALL pulse.
REQ-030 err_o SHALL be registered and SHALL be 1 for exactly one cycle per error.
REQ-031 Data SHALL pass unmodified unless the Configuration section below says otherwise.

Reset
REQ-032 While rst_ni=0, asynchronously: both banks FREE, both pointers at bank A, widx=0.
REQ-033 While rst_ni=0: s_ready_o=0, frame_valid_o=0, err_o=0.
REQ-034 Bank contents SHALL need no reset; frame_o SHALL be qualified by frame_valid_o only.
REQ-035 Deassertion of rst_ni SHALL take effect at a clock edge; s_ready_o SHALL be 1 on the first cycle after release.
REQ-036 Reset mid-frame or mid-hold SHALL discard all data; no frame_valid_o SHALL follow unless a fresh complete frame is received.

Configuration
REQ-037 With macro FFT_LOADER_PRESCALE_EN defined, each component SHALL be stored arithmetically shifted right by POINT_FFT_POW2 (sign-extended, truncated toward -inf), to give headroom for FFT growth.
REQ-038 With FFT_LOADER_PRESCALE_EN undefined, components SHALL be stored unchanged.
REQ-039 Handshake, timing and reset behaviour SHALL be identical in both builds.

Verification
REQ-040 Scenario, frame_ready_i=1: send 16 samples Re=k*1000, Im=-k, last on k=15 -> frame_valid_o rises 1 cycle after sample 15, frame_o[k] matches (prescale build: Re=(k*1000)>>>4), err_o never pulses.
REQ-041 Scenario, frame_ready_i=0: stream 40 samples -> s_ready_o falls after the 32nd acceptance, frame 0 is held stable, frame_ready_i=1 for one cycle -> frame 1 is presented next cycle and s_ready_o returns to 1.
REQ-042 Scenario: s_last_i at k=5 -> err_o pulses once; the next 16 samples form a clean frame starting with the sample after k=5.
REQ-043 Scenario: no s_last_i at k=15 -> frame is published and err_o pulses once.
REQ-044 Scenario: complete frame 1 on the same edge that frame 0 is consumed -> frame 1 is valid the next cycle and no frame is dropped.
REQ-045 Scenario: rst_ni=0 asserted asynchronously mid-frame after 7 samples -> outputs go to 0 immediately, and after release a full 16-sample frame is required before frame_valid_o.
